// File: rtl/scan_cfg_pkg.sv
// Shared types and frame-length helpers for the scan configuration controller.
// Build option: define SCAN_PARITY_EN to append an even-parity bit to every frame.
package scan_cfg_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

`ifdef SCAN_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int frame_len(input int depth);
    return depth + PAR_BITS;
  endfunction

  // Counter must hold FRAME+1 (over-long frame marker).
  function automatic int cnt_width(input int frame);
    return $clog2(frame + 2);
  endfunction

endpackage

// File: rtl/scan_lane.sv
// One scan lane: shadow shift register, registered readback/loopback, and
// (with SCAN_PARITY_EN) a running parity accumulator reset at frame start.
module scan_lane #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             se,
  input  logic             shift_en,
  input  logic             lb,
  input  logic             sc_in,
`ifdef SCAN_PARITY_EN
  input  logic             frame_start,
  output logic             par,
`endif
  output logic             sc_out,
  output logic [DEPTH-1:0] shadow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      sc_out <= 1'b0;
    end else begin
      if (shift_en) shadow <= {shadow[DEPTH-2:0], sc_in};
      if (lb)       sc_out <= sc_in;
      else if (se)  sc_out <= shadow[DEPTH-1];
    end
  end

`ifdef SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)     par <= 1'b0;
    else if (se) par <= frame_start ? sc_in : (par ^ sc_in);
  end
`endif

endmodule

// File: rtl/scan_cfg_ctrl.sv
// Multi-lane scan configuration controller: frame-length check, atomic commit
// of the shadow chains to cfg_out. Optional parity check via SCAN_PARITY_EN.
module scan_cfg_ctrl
  import scan_cfg_pkg::*;
#(
  parameter int CHAINS = 2,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     se,
  input  logic [CHAINS-1:0]        sc_in,
  input  logic                     lb,
  output logic [CHAINS-1:0]        sc_out,
  output logic [CHAINS*DEPTH-1:0]  cfg_out,
  output logic                     cfg_upd,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int FRAME = frame_len(DEPTH);
  localparam int CW    = cnt_width(FRAME);
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME);
  localparam logic [CW-1:0] SAT_C   = CW'(FRAME + 1);

  state_t                        state, state_nx;
  logic [CW-1:0]                 count, count_nx;
  logic                          err_nx, frame_start, shift_en, par_ok;
  logic [CHAINS-1:0][DEPTH-1:0]  shadow, cfg_q;

`ifdef SCAN_PARITY_EN
  logic [CHAINS-1:0] par;
  logic              par_cyc;
  // Bit DEPTH+1 of a frame is the parity bit: folded into parity, never shifted.
  assign par_cyc  = (state == SHIFT) && (count == CW'(DEPTH));
  assign shift_en = se & ~par_cyc;
  assign par_ok   = ~|par;
`else
  assign shift_en = se;
  assign par_ok   = 1'b1;
`endif

  for (genvar k = 0; k < CHAINS; k++) begin : g_lane
    scan_lane #(.DEPTH(DEPTH)) u_lane (
`ifdef SCAN_PARITY_EN
      .frame_start (frame_start),
      .par         (par[k]),
`endif
      .clk         (clk),
      .rst         (rst),
      .se          (se),
      .shift_en    (shift_en),
      .lb          (lb),
      .sc_in       (sc_in[k]),
      .sc_out      (sc_out[k]),
      .shadow      (shadow[k])
    );
  end

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    err_nx      = frame_err;
    frame_start = 1'b0;
    case (state)
      IDLE, UPDATE: begin
        state_nx = IDLE;
        if (se) begin
          state_nx    = SHIFT;
          count_nx    = CW'(1);
          err_nx      = 1'b0;
          frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (se) begin
          if (count != SAT_C) count_nx = count + CW'(1);
        end else if (count == FRAME_C && par_ok) begin
          state_nx = UPDATE;
        end else begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      frame_err <= 1'b0;
      cfg_upd   <= 1'b0;
      cfg_q     <= '0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      frame_err <= err_nx;
      cfg_upd   <= (state == UPDATE);
      if (state == UPDATE) cfg_q <= shadow;
    end
  end

  assign cfg_out = cfg_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_scan_cfg_ctrl.sv
// Self-checking bench for scan_cfg_ctrl (CHAINS=2, DEPTH=16): directed corner
// sequences, a loopback vector table and random frames against a queue model.
module tb_scan_cfg_ctrl;
  localparam int CHAINS = 2;
  localparam int DEPTH  = 16;
`ifdef SCAN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = DEPTH + PAR;

  logic        clk = 1'b0, rst = 1'b1, se = 1'b0, lb = 1'b0;
  logic [1:0]  sc_in = 2'b00;
  logic [1:0]  sc_out;
  logic [31:0] cfg_out;
  logic        cfg_upd, frame_err, busy;

  scan_cfg_ctrl #(.CHAINS(CHAINS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .se(se), .sc_in(sc_in), .lb(lb),
    .sc_out(sc_out), .cfg_out(cfg_out), .cfg_upd(cfg_upd),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Model: each lane's shadow is the last DEPTH bits shifted (front = oldest = MSB).
  bit          q0[$], q1[$];
  logic [1:0]  e_sco, mpar;
  logic [31:0] e_cfg, pend_cfg;
  logic        e_upd, e_err, e_busy, pend;
  int          pos;
  bit          in_frame;

  typedef struct {
    logic       lb;
    logic       se;
    logic [1:0] din;
    logic [1:0] exp_sco;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_cfg();
    logic [31:0] p = '0;
    for (int i = 0; i < DEPTH; i++) begin
      p[DEPTH-1-i]    = q0[i];
      p[16+DEPTH-1-i] = q1[i];
    end
    return p;
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    for (int i = 0; i < DEPTH; i++) begin q0.push_back(1'b0); q1.push_back(1'b0); end
    e_sco = '0; e_cfg = '0; e_upd = 0; e_err = 0; e_busy = 0;
    pend = 0; pos = 0; in_frame = 0; mpar = '0; pend_cfg = '0;
  endtask

  task automatic tick(input logic r, input logic s, input logic l, input logic [1:0] d);
    bit o0, o1;
    rst = r; se = s; lb = l; sc_in = d;
    @(posedge clk); #1;
    if (r) model_reset();
    else begin
      e_upd = pend;
      if (pend) e_cfg = pend_cfg;
      pend = 0;
      if (s) begin
        if (!in_frame) begin pos = 0; mpar = '0; e_err = 0; end
        in_frame = 1;
        pos++;
        mpar ^= d;
        if (PAR == 1 && pos == DEPTH + 1) begin
          o0 = q0[0]; o1 = q1[0];
        end else begin
          o0 = q0.pop_front(); o1 = q1.pop_front();
          q0.push_back(d[0]); q1.push_back(d[1]);
        end
        if (!l) e_sco = {o1, o0};
      end else if (in_frame) begin
        in_frame = 0;
        if (pos == FRAME && (PAR == 0 || mpar == 2'b00)) begin
          pend = 1; pend_cfg = model_cfg();
        end else e_err = 1;
      end
      if (l) e_sco = d;
      e_busy = s || pend;
    end
    chk("cfg_out",   cfg_out,   e_cfg);
    chk("cfg_upd",   cfg_upd,   e_upd);
    chk("frame_err", frame_err, e_err);
    chk("busy",      busy,      e_busy);
    chk("sc_out",    sc_out,    e_sco);
  endtask

  // Shift n bits per lane, MSB first; bit DEPTH is the parity bit when enabled.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input int n,
                      input logic l, input bit badpar);
    logic [1:0] d;
    for (int i = 0; i < n; i++) begin
      if (i < DEPTH)                     d = {b[15-i], a[15-i]};
      else if (PAR == 1 && i == DEPTH)   d = {(^b) ^ badpar, ^a};
      else                               d = 2'b00;
      tick(0, 1, l, d);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 2'b01, 2'b01};
    tbl[1] = '{1'b1, 1'b0, 2'b10, 2'b10};
    tbl[2] = '{1'b1, 1'b0, 2'b01, 2'b01};
    tbl[3] = '{1'b1, 1'b0, 2'b11, 2'b11};
    tbl[4] = '{1'b1, 1'b0, 2'b00, 2'b00};
    tbl[5] = '{1'b0, 1'b0, 2'b11, 2'b00};

    model_reset();
    tick(1, 0, 0, 2'b00);
    chk("reset_cfg", cfg_out, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    tick(0, 0, 0, 2'b00);

    // 1: basic commit, two-edge latency
    send(16'hA5C3, 16'h1234, FRAME, 0, 0);
    tick(0, 0, 0, 2'b00);
    chk("t1_upd_early", {31'd0, cfg_upd}, 32'h0);
    tick(0, 0, 0, 2'b00);
    chk("t1_upd", {31'd0, cfg_upd}, 32'h1);
    chk("t1_cfg", cfg_out, 32'h1234_A5C3);
    chk("t1_err", {31'd0, frame_err}, 32'h0);
    tick(0, 0, 0, 2'b00);

    // 2: short frame rejected, next good frame clears error
    send(16'hFFFF, 16'hFFFF, FRAME - 1, 0, 0);
    tick(0, 0, 0, 2'b00);
    chk("t2_err", {31'd0, frame_err}, 32'h1);
    tick(0, 0, 0, 2'b00);
    chk("t2_noupd", {31'd0, cfg_upd}, 32'h0);
    chk("t2_keep", cfg_out, 32'h1234_A5C3);
    send(16'h0F0F, 16'hF0F0, FRAME, 0, 0);
    tick(0, 0, 0, 2'b00);
    chk("t2_clr", {31'd0, frame_err}, 32'h0);
    tick(0, 0, 0, 2'b00);
    chk("t2_cfg", cfg_out, 32'hF0F0_0F0F);

    // 3: over-long frame, then readback of 0xFFFF
    send(16'h5555, 16'hAAAA, DEPTH + 4, 0, 0);
    tick(0, 0, 0, 2'b00);
    chk("t3_err", {31'd0, frame_err}, 32'h1);
    tick(0, 0, 0, 2'b00);
    chk("t3_noupd", {31'd0, cfg_upd}, 32'h0);
    chk("t3_keep", cfg_out, 32'hF0F0_0F0F);
    send(16'hFFFF, 16'hFFFF, FRAME, 0, 0);
    tick(0, 0, 0, 2'b00);
    tick(0, 0, 0, 2'b00);
    for (int i = 0; i < DEPTH; i++) begin
      tick(0, 1, 0, 2'b00);
      chk("t3_readback", {30'd0, sc_out}, 32'h3);
    end
    tick(0, 0, 0, 2'b00);
    tick(0, 0, 0, 2'b00);

    // 4: loopback table, then a frame shifted with lb=1 still commits
    foreach (tbl[i]) begin
      tick(0, tbl[i].se, tbl[i].lb, tbl[i].din);
      chk("t4_loop", {30'd0, sc_out}, {30'd0, tbl[i].exp_sco});
    end
    send(16'h00FF, 16'hC3C3, FRAME, 1, 0);
    tick(0, 0, 1, 2'b00);
    tick(0, 0, 1, 2'b00);
    chk("t4_upd", {31'd0, cfg_upd}, 32'h1);
    chk("t4_cfg", cfg_out, 32'hC3C3_00FF);

    // 5: reset mid-frame
    send(16'h1357, 16'h2468, 8, 0, 0);
    tick(1, 0, 0, 2'b00);
    chk("t5_cfg", cfg_out, 32'h0);
    chk("t5_flags", {28'd0, cfg_upd, frame_err, busy, 1'b0}, 32'h0);
    chk("t5_sco", {30'd0, sc_out}, 32'h0);
    send(16'hBEEF, 16'hCAFE, FRAME, 0, 0);
    tick(0, 0, 0, 2'b00);
    tick(0, 0, 0, 2'b00);
    chk("t5_cfg2", cfg_out, 32'hCAFE_BEEF);

    // 6: second frame starts in the UPDATE cycle
    send(16'h1111, 16'h2222, FRAME, 0, 0);
    tick(0, 0, 0, 2'b00);
    send(16'h3333, 16'h4444, 1, 0, 0);
    chk("t6_upd", {31'd0, cfg_upd}, 32'h1);
    chk("t6_cfg", cfg_out, 32'h2222_1111);
    send(16'h3333 << 1, 16'h4444 << 1, FRAME - 1, 0, 0);
    tick(0, 0, 0, 2'b00);
    tick(0, 0, 0, 2'b00);
    chk("t6_cfg2", cfg_out, 32'h4444_3333);
`ifdef SCAN_PARITY_EN
    send(16'h0101, 16'h0303, FRAME, 0, 1);
    tick(0, 0, 0, 2'b00);
    chk("t6_par_err", {31'd0, frame_err}, 32'h1);
    tick(0, 0, 0, 2'b00);
    chk("t6_par_noupd", {31'd0, cfg_upd}, 32'h0);
    chk("t6_par_keep", cfg_out, 32'h4444_3333);
`endif

    // Random frames against the model
    for (int f = 0; f < 40; f++) begin
      int n;
      case ($urandom_range(0, 5))
        0:       n = FRAME - 1;
        3:       n = FRAME + 1;
        4:       n = $urandom_range(1, FRAME + 4);
        default: n = FRAME;
      endcase
      send(16'($urandom), 16'($urandom), n, 1'($urandom), (PAR == 1) && ($urandom_range(0, 3) == 0));
      for (int g = 0; g < int'($urandom_range(1, 3)); g++)
        tick(0, 0, 1'($urandom), 2'($urandom));
    end
    tick(0, 0, 0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_cfg_ctrl.md
Name: scan_cfg_ctrl

Overview:
Parametrised multi-lane scan-chain configuration controller for the rotating-tile FPGA fabric. It is the successor to the single fixed-length scan path. It accepts CHAINS parallel serial bitstreams under a scan-enable, validates frame length (and optionally parity), and atomically commits the shadow chain to the live configuration bus. It also provides per-lane readback and a loopback mode for board-level continuity checks.

Parameters:
CHAINS, 2, number of parallel scan lanes (1..8)
DEPTH, 16, configuration bits per lane (2..256)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
se  input  1  scan enable; high = shift one bit per lane per cycle
sc_in  input  CHAINS  serial data, one bit per lane
lb  input  1  loopback select
sc_out  output  CHAINS  serial readback, registered
cfg_out  output  CHAINS*DEPTH  live configuration; lane k occupies bits [k*DEPTH +: DEPTH]
cfg_upd  output  1  one-cycle pulse when cfg_out is committed
frame_err  output  1  last frame rejected
busy  output  1  high in SHIFT or UPDATE

Behaviour:
- Reset (rst=1 at clk edge) clears the following, from any state including mid-frame, and discards the partial frame:
  - shadow = 0, cfg_out = 0, sc_out = 0, cfg_upd = 0, frame_err = 0, count = 0, state = IDLE.
- FRAME = DEPTH (DEPTH+1 with parity feature). count width = clog2(FRAME+2), saturates at FRAME+1.
- Shift, per lane, on any cycle with se=1:
  - shadow <= {shadow[DEPTH-2:0], sc_in[k]}
  - The first bit of a frame ends at shadow[DEPTH-1].
- sc_out:
  - lb=0: sc_out[k] <= shadow[k][DEPTH-1] (the bit being shifted out) when se=1; holds when se=0.
  - lb=1: sc_out <= sc_in every cycle, regardless of se. Shift, count and FSM are unaffected by lb.
- FSM states IDLE, SHIFT, UPDATE:
  - IDLE: se=1 -> SHIFT, count <= 1, frame_err <= 0. se=0 -> stay.
  - SHIFT, se=1: shift, count <= min(count+1, FRAME+1).
  - SHIFT, se=0, count==FRAME (and parity ok): -> UPDATE.
  - SHIFT, se=0, otherwise (short, over-long or parity fail): -> IDLE, frame_err <= 1, cfg_out unchanged.
  - UPDATE (exactly one cycle): cfg_out <= shadow value at the start of the cycle; cfg_upd = 1 (registered, high during the cycle after the SHIFT->UPDATE edge).
  - UPDATE, se=1 in the same cycle: that bit is shifted and starts a new frame (count <= 1, -> SHIFT). Otherwise -> IDLE.
- Latency: last frame bit sampled at edge N. se low at edge N+1 -> UPDATE. cfg_out valid and cfg_upd high after edge N+2.
- frame_err is sticky until the next frame start (IDLE->SHIFT, or UPDATE with se=1).
- busy = (state != IDLE).

Optional Feature:
- Macro SCAN_PARITY_EN.
- Defined:
  - Frame is DEPTH+1 bits; the final bit per lane is an even-parity bit.
  - The parity cycle does not shift the shadow; it only folds into a per-lane running parity register, which clears at frame start.
  - Commit requires the XOR of all DEPTH+1 bits to be 0 on every lane; any lane failing -> frame_err, no commit.
- Undefined: frame is DEPTH bits and there is no parity logic.

Decomposition:
- Package scan_cfg_pkg: state enum (IDLE/SHIFT/UPDATE), function cnt_width(frame), localparam FRAME derivation.
- One sub-module scan_lane: a single lane's shadow shift register, sc_out/loopback register and parity accumulator, instantiated CHAINS times via generate.
- FSM and counter stay in the top level.

Test Plan (CHAINS=2, DEPTH=16):
1. Reset, then shift 16 cycles with lane0 = 0xA5C3 and lane1 = 0x1234 (MSB first), drop se -> cfg_upd pulse two edges after the last bit, cfg_out=0x1234_A5C3, frame_err=0.
2. Shift 15 bits then drop se -> frame_err=1, cfg_upd never asserts, cfg_out keeps the previous value; the next valid frame clears frame_err.
3. Shift 20 bits -> count saturates, frame_err=1, no commit. Then load 0xFFFF per lane and re-shift 16 zeros -> sc_out emits 16 ones per lane.
4. lb=1 with se=0, toggle sc_in=2'b01/2'b10 -> sc_out follows one cycle later. Shift a full frame with lb=1 -> the commit still occurs.
5. Assert rst at bit 8 of a frame -> all outputs 0. A following full frame commits normally.
6. Hold se high across UPDATE (se low for one cycle between frames, then high) -> the first frame commits, the second frame's bit counts as bit 1. With SCAN_PARITY_EN, a frame with a wrong parity bit on lane1 -> frame_err=1, no cfg_upd.
